// File: rtl/ct_spsram_ctrl_pkg.sv
// Shared types and helpers for the 2048x32 single-port SRAM controller.
package ct_spsram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic REQ0_ID = 1'b0;
    localparam logic REQ1_ID = 1'b1;

    // One active-high byte enable becomes eight active-low bit write enables.
    function automatic logic [7:0] byte_wen(input logic be);
        return {8{~be}};
    endfunction

endpackage

// File: rtl/ct_spsram_rr_arb.sv
// Two-way round-robin arbiter; the pointer only moves when both requesters compete.
module ct_spsram_rr_arb
    import ct_spsram_ctrl_pkg::*;
(
    input  logic       forever_cpuclk,
    input  logic       cpurst,
    input  logic [1:0] vld,
    output logic [1:0] grnt
);

    logic ptr;  // 0 favours req0, 1 favours req1

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        grnt = 2'b00;
        case (vld)
            2'b01:   grnt = 2'b01;
            2'b10:   grnt = 2'b10;
            2'b11:   grnt = ptr ? 2'b10 : 2'b01;
            default: grnt = 2'b00;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst)
            ptr <= REQ0_ID;
        else if (vld == 2'b11)
            ptr <= ~ptr;
    end

endmodule

// File: rtl/ct_spsram_2048x32_ctrl.sv
// Shares one single-port SRAM between two requesters after an optional clear sweep.
module ct_spsram_2048x32_ctrl
    import ct_spsram_ctrl_pkg::*;
#(
    parameter int                      ADDR_WIDTH = 11,
    parameter int                      DATA_WIDTH = 32,
    parameter int                      INIT_EN    = 1,
    parameter logic [DATA_WIDTH-1:0]   INIT_VALUE = '0
) (
    input  logic                    forever_cpuclk,
    input  logic                    cpurst,
    input  logic                    req0_vld,
    input  logic                    req0_wr,
    input  logic [ADDR_WIDTH-1:0]   req0_addr,
    input  logic [DATA_WIDTH-1:0]   req0_wdata,
    input  logic [DATA_WIDTH/8-1:0] req0_be,
    output logic                    req0_grnt,
    input  logic                    req1_vld,
    input  logic                    req1_wr,
    input  logic [ADDR_WIDTH-1:0]   req1_addr,
    input  logic [DATA_WIDTH-1:0]   req1_wdata,
    input  logic [DATA_WIDTH/8-1:0] req1_be,
    output logic                    req1_grnt,
    output logic                    rd_vld,
    output logic                    rd_id,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    init_done,
    output logic                    sram_cen,
    output logic                    sram_gwen,
    output logic [DATA_WIDTH-1:0]   sram_wen,
    output logic [ADDR_WIDTH-1:0]   sram_a,
    output logic [DATA_WIDTH-1:0]   sram_d,
    input  logic [DATA_WIDTH-1:0]   sram_q
);

    localparam int BE_W = DATA_WIDTH / 8;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   init_cnt;
    logic [ADDR_WIDTH-1:0]   a_hold;
    logic [DATA_WIDTH-1:0]   d_hold;
    logic [1:0]              grnt;
    logic                    sel;
    logic                    any_grnt;
    logic                    acc_wr;
    logic [ADDR_WIDTH-1:0]   acc_addr;
    logic [DATA_WIDTH-1:0]   acc_wdata;
    logic [BE_W-1:0]         acc_be;
    logic [DATA_WIDTH-1:0]   acc_wen;
    logic                    rd_issue;

    ct_spsram_rr_arb u_arb (
        .forever_cpuclk (forever_cpuclk),
        .cpurst         (cpurst),
        .vld            ({req1_vld, req0_vld} & {2{state == ST_RUN}}),
        .grnt           (grnt)
    );

    assign req0_grnt = grnt[0];
    assign req1_grnt = grnt[1];
    assign any_grnt  = |grnt;
    assign sel       = grnt[1] ? REQ1_ID : REQ0_ID;
    assign acc_wr    = sel ? req1_wr    : req0_wr;
    assign acc_addr  = sel ? req1_addr  : req0_addr;
    assign acc_wdata = sel ? req1_wdata : req0_wdata;
    assign acc_be    = sel ? req1_be    : req0_be;
    assign rd_issue  = any_grnt & ~acc_wr;

    for (genvar i = 0; i < BE_W; i++) begin : g_wen
        assign acc_wen[8*i +: 8] = byte_wen(acc_be[i]);
    end

    // The macro samples its pins at the clock edge, so the drive is combinational
    // from the grant; address and data park on their last values when idle.
    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = a_hold;
        sram_d    = d_hold;
        case (state)
            ST_INIT: begin
                sram_cen  = 1'b0;
                sram_gwen = 1'b0;
                sram_wen  = '0;
                sram_a    = init_cnt;
                sram_d    = INIT_VALUE;
            end
            ST_RUN: begin
                if (any_grnt) begin
                    sram_cen = 1'b0;
                    sram_a   = acc_addr;
                    sram_d   = acc_wdata;
                    if (acc_wr) begin
                        sram_gwen = 1'b0;
                        sram_wen  = acc_wen;
                    end
                end
            end
            default: ;
        endcase
    end

    assign rd_data = rd_vld ? sram_q : '0;

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state     <= ST_WAIT;
            init_cnt  <= '0;
            init_done <= 1'b0;
            a_hold    <= '0;
            d_hold    <= '0;
            rd_vld    <= 1'b0;
            rd_id     <= REQ0_ID;
        end else begin
            a_hold <= sram_a;
            d_hold <= sram_d;
            rd_vld <= rd_issue;
            if (rd_issue)
                rd_id <= sel;
            case (state)
                ST_WAIT: begin
                    if (INIT_EN != 0) begin
                        state <= ST_INIT;
                    end else begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == '1) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN:  state <= ST_RUN;
                default: state <= ST_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ct_spsram_2048x32_ctrl.sv
// Directed bench for the SRAM controller with a behavioural macro model.
module tb_ct_spsram_2048x32_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_vld, req0_wr, req1_vld, req1_wr;
    logic [10:0] req0_addr, req1_addr;
    logic [31:0] req0_wdata, req1_wdata;
    logic [3:0]  req0_be, req1_be;
    logic        req0_grnt, req1_grnt, rd_vld, rd_id, init_done;
    logic [31:0] rd_data;
    logic        sram_cen, sram_gwen;
    logic [31:0] sram_wen, sram_d, sram_q;
    logic [10:0] sram_a;

    // INIT_EN=0 instance
    logic        n_rst;
    logic        n_req0_vld, n_req0_wr, n_req1_vld, n_req1_wr;
    logic [10:0] n_req0_addr, n_req1_addr;
    logic [31:0] n_req0_wdata, n_req1_wdata;
    logic [3:0]  n_req0_be, n_req1_be;
    logic        n_req0_grnt, n_req1_grnt, n_rd_vld, n_rd_id, n_init_done;
    logic [31:0] n_rd_data;
    logic        n_sram_cen, n_sram_gwen;
    logic [31:0] n_sram_wen, n_sram_d;
    logic [31:0] n_sram_q = 32'h0;
    logic [10:0] n_sram_a;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ct_spsram_2048x32_ctrl u_dut (
        .forever_cpuclk(clk), .cpurst(rst),
        .req0_vld(req0_vld), .req0_wr(req0_wr), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_be(req0_be), .req0_grnt(req0_grnt),
        .req1_vld(req1_vld), .req1_wr(req1_wr), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_be(req1_be), .req1_grnt(req1_grnt),
        .rd_vld(rd_vld), .rd_id(rd_id), .rd_data(rd_data), .init_done(init_done),
        .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
        .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
    );

    ct_spsram_2048x32_ctrl #(.INIT_EN(0)) u_dut_noinit (
        .forever_cpuclk(clk), .cpurst(n_rst),
        .req0_vld(n_req0_vld), .req0_wr(n_req0_wr), .req0_addr(n_req0_addr),
        .req0_wdata(n_req0_wdata), .req0_be(n_req0_be), .req0_grnt(n_req0_grnt),
        .req1_vld(n_req1_vld), .req1_wr(n_req1_wr), .req1_addr(n_req1_addr),
        .req1_wdata(n_req1_wdata), .req1_be(n_req1_be), .req1_grnt(n_req1_grnt),
        .rd_vld(n_rd_vld), .rd_id(n_rd_id), .rd_data(n_rd_data), .init_done(n_init_done),
        .sram_cen(n_sram_cen), .sram_gwen(n_sram_gwen), .sram_wen(n_sram_wen),
        .sram_a(n_sram_a), .sram_d(n_sram_d), .sram_q(n_sram_q)
    );

    // Macro model: bit-masked writes, registered reads, nonzero power-up contents.
    logic [31:0] mem [0:2047];
    initial for (int i = 0; i < 2048; i++) mem[i] = 32'hA5A5_A5A5;

    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen) begin
                for (int b = 0; b < 32; b++)
                    if (!sram_wen[b]) mem[sram_a][b] <= sram_d[b];
            end else begin
                sram_q <= mem[sram_a];
            end
        end
    end

    // Sweep monitor, cleared whenever reset asserts.
    int init_writes = 0, init_dup = 0, init_bad = 0, early_grant = 0;
    bit seen [0:2047];
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            init_writes = 0; init_dup = 0; init_bad = 0; early_grant = 0;
            for (int i = 0; i < 2048; i++) seen[i] = 1'b0;
        end else if (!init_done) begin
            if (!sram_cen && !sram_gwen) begin
                init_writes++;
                if (seen[sram_a]) init_dup++;
                seen[sram_a] = 1'b1;
                if (sram_d !== 32'h0 || sram_wen !== 32'h0) init_bad++;
            end
            if (req0_grnt || req1_grnt) early_grant++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req0(input logic v, input logic wr, input logic [10:0] a,
                            input logic [31:0] d, input logic [3:0] be);
        req0_vld = v; req0_wr = wr; req0_addr = a; req0_wdata = d; req0_be = be;
    endtask

    task automatic set_req1(input logic v, input logic wr, input logic [10:0] a,
                            input logic [31:0] d, input logic [3:0] be);
        req1_vld = v; req1_wr = wr; req1_addr = a; req1_wdata = d; req1_be = be;
    endtask

    task automatic wait_init(output int n, output logic [10:0] first_a);
        n = 0;
        first_a = '1;
        while (!init_done && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) first_a = sram_a;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cen"},   sram_cen, 1'b1);
        check({tag, "_gwen"},  sram_gwen, 1'b1);
        check({tag, "_wen"},   sram_wen, 32'hFFFF_FFFF);
        check({tag, "_a"},     sram_a, 11'h000);
        check({tag, "_d"},     sram_d, 32'h0);
        check({tag, "_grnt"},  {req1_grnt, req0_grnt}, 2'b00);
        check({tag, "_rdvld"}, rd_vld, 1'b0);
        check({tag, "_rdid"},  rd_id, 1'b0);
        check({tag, "_rddat"}, rd_data, 32'h0);
        check({tag, "_done"},  init_done, 1'b0);
    endtask

    task automatic check_sweep(input string tag);
        int          n;
        logic [10:0] fa;
        wait_init(n, fa);
        check({tag, "_latency"}, n, 2049);
        check({tag, "_first_a"}, fa, 11'h000);
        check({tag, "_writes"},  init_writes, 2048);
        check({tag, "_dup"},     init_dup, 0);
        check({tag, "_data"},    init_bad, 0);
        check({tag, "_early"},   early_grant, 0);
    endtask

    initial begin
        rst = 1'b1;
        n_rst = 1'b1;
        set_req0(1'b1, 1'b0, 11'h0, 32'h0, 4'h0);
        set_req1(1'b1, 1'b0, 11'h0, 32'h0, 4'h0);
        {n_req0_vld, n_req0_wr, n_req0_addr, n_req0_wdata, n_req0_be} = '0;
        {n_req1_vld, n_req1_wr, n_req1_addr, n_req1_wdata, n_req1_be} = '0;
        #3;
        check_reset_outputs("rst");

        // Power-up sweep, with both requesters asking throughout
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_sweep("sweep");

        // Masked write then read-back
        @(negedge clk);
        set_req1(1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
        set_req0(1'b1, 1'b1, 11'h005, 32'hDEAD_BEEF, 4'b0101);
        #1;
        check("wr_grnt", {req1_grnt, req0_grnt}, 2'b01);
        check("wr_cen",  sram_cen, 1'b0);
        check("wr_gwen", sram_gwen, 1'b0);
        check("wr_wen",  sram_wen, 32'hFF00_FF00);
        check("wr_a",    sram_a, 11'h005);
        check("wr_d",    sram_d, 32'hDEAD_BEEF);
        @(negedge clk);
        set_req0(1'b1, 1'b0, 11'h005, 32'h0, 4'h0);
        #1;
        check("rd_grnt",  req0_grnt, 1'b1);
        check("rd_gwen",  sram_gwen, 1'b1);
        check("rd_wen",   sram_wen, 32'hFFFF_FFFF);
        check("rd_nodat", rd_vld, 1'b0);
        @(negedge clk);
        set_req0(1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
        #1;
        check("rd_vld",    rd_vld, 1'b1);
        check("rd_id0",    rd_id, 1'b0);
        check("rd_data",   rd_data, 32'h00AD_00EF);
        check("idle_cen",  sram_cen, 1'b1);
        check("idle_hold", sram_a, 11'h005);

        // Contested reads alternate and stream back-to-back
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_req0(1'b1, 1'b0, 11'h100, 32'h0, 4'h0);
            set_req1(1'b1, 1'b0, 11'h200, 32'h0, 4'h0);
            #1;
            check($sformatf("rr_grnt%0d", i), {req1_grnt, req0_grnt}, (i % 2) ? 2'b10 : 2'b01);
            check($sformatf("rr_a%0d", i), sram_a, (i % 2) ? 11'h200 : 11'h100);
            check($sformatf("rr_vld%0d", i), rd_vld, (i > 0) ? 1'b1 : 1'b0);
            if (i > 0) begin
                check($sformatf("rr_id%0d", i), rd_id, ((i - 1) % 2) ? 1'b1 : 1'b0);
                check($sformatf("rr_dat%0d", i), rd_data, 32'h0);
            end
        end

        // req1 write followed immediately by req0 read of the same address
        @(negedge clk);
        set_req0(1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
        set_req1(1'b1, 1'b1, 11'h7FF, 32'h1234_5678, 4'hF);
        #1;
        check("raw_wgrnt", {req1_grnt, req0_grnt}, 2'b10);
        check("raw_wen",   sram_wen, 32'h0);
        check("raw_a",     sram_a, 11'h7FF);
        check("raw_lastid", rd_id, 1'b1);
        @(negedge clk);
        set_req1(1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
        set_req0(1'b1, 1'b0, 11'h7FF, 32'h0, 4'h0);
        #1;
        check("raw_rgrnt", {req1_grnt, req0_grnt}, 2'b01);
        @(negedge clk);
        set_req0(1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
        #1;
        check("raw_vld",  rd_vld, 1'b1);
        check("raw_id",   rd_id, 1'b0);
        check("raw_data", rd_data, 32'h1234_5678);

        // Zero byte-enable write is issued but changes nothing
        @(negedge clk);
        set_req1(1'b1, 1'b1, 11'h005, 32'hFFFF_FFFF, 4'h0);
        #1;
        check("be0_grnt", req1_grnt, 1'b1);
        check("be0_cen",  sram_cen, 1'b0);
        check("be0_gwen", sram_gwen, 1'b0);
        check("be0_wen",  sram_wen, 32'hFFFF_FFFF);
        @(negedge clk);
        set_req0(1'b1, 1'b0, 11'h005, 32'h0, 4'h0);
        set_req1(1'b1, 1'b0, 11'h200, 32'h0, 4'h0);
        #1;
        check("be0_both_grnt", {req1_grnt, req0_grnt}, 2'b01);
        check("be0_both_a",    sram_a, 11'h005);
        @(negedge clk);
        set_req0(1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
        #1;
        check("held_grnt", {req1_grnt, req0_grnt}, 2'b10);
        check("held_a",    sram_a, 11'h200);
        check("be0_data",  rd_data, 32'h00AD_00EF);
        @(negedge clk);
        set_req1(1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
        #1;
        check("held_id", rd_id, 1'b1);

        // Reset in RUN drops a pending read return
        @(negedge clk);
        set_req0(1'b1, 1'b0, 11'h005, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        check("mid_run_vld", rd_vld, 1'b1);
        rst = 1'b1;
        #1;
        check_reset_outputs("run_rst");

        // Reset partway through the sweep restarts it from address 0
        set_req1(1'b1, 1'b0, 11'h0, 32'h0, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (1001) @(posedge clk);
        #1;
        check("mid_init_a",   sram_a, 11'd1000);
        check("mid_init_cen", sram_cen, 1'b0);
        rst = 1'b1;
        #1;
        check_reset_outputs("init_rst");
        @(negedge clk);
        rst = 1'b0;
        check_sweep("resweep");
        @(negedge clk);
        set_req0(1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
        set_req1(1'b0, 1'b0, 11'h0, 32'h0, 4'h0);

        // INIT_EN=0 instance runs without a sweep
        @(negedge clk);
        check("noinit_rst_done", n_init_done, 1'b0);
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("noinit_done", n_init_done, 1'b1);
        @(negedge clk);
        n_req1_vld = 1'b1;
        n_req1_wr = 1'b0;
        n_req1_addr = 11'h000;
        #1;
        check("noinit_grnt", {n_req1_grnt, n_req0_grnt}, 2'b10);
        check("noinit_cen",  n_sram_cen, 1'b0);
        @(negedge clk);
        n_req1_vld = 1'b0;
        #1;
        check("noinit_rdvld", n_rd_vld, 1'b1);
        check("noinit_rdid",  n_rd_id, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
